// File: rtl/debug_host_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debug_host_sequencer: loads a program into the harness code ROM and     |
// | issues RUN/HALT/STEP debug commands. Option: DEBUG_HOST_TIMEOUT_EN.     |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module debug_host_sequencer #(
  parameter int ROM_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [11:0] load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_code,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic        busy,
  output logic [3:0]  debug_cmd,
  input  logic        command_complete,
  output logic [7:0]  rom_wr_data,
  output logic [11:0] rom_wr_addr,
  output logic        program_rom_mode,
  output logic        reset_code_rom_n
);

  if (ROM_BYTES < 1 || ROM_BYTES > 4096) begin : g_bad_rom_bytes
    $error("debug_host_sequencer: ROM_BYTES out of range 1..4096");
  end

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("debug_host_sequencer: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    LOAD      = 3'd2,
    FLUSH     = 3'd3,
    CMD_ISSUE = 3'd4,
    CMD_WAIT  = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        err_q, err_d;
`ifdef DEBUG_HOST_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`endif

  logic len_bad;
  logic cmd_bad;
  logic last_byte;

  assign len_bad   = (load_len == 12'd0) || (int'(load_len) > ROM_BYTES);
  assign cmd_bad   = (cmd_code == 4'd0) || (cmd_code > 4'd3);
  assign last_byte = (cnt_q == len_q - 12'd1);

  assign rom_wr_data = data_q;
  assign rom_wr_addr = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
`ifdef DEBUG_HOST_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    data_d           = data_q;
    cmd_d            = cmd_q;
    err_d            = err_q;
`ifdef DEBUG_HOST_TIMEOUT_EN
    tmo_d            = tmo_q;
`endif
    byte_ready       = 1'b0;
    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_error        = 1'b0;
    busy             = 1'b1;
    debug_cmd        = 4'd0;
    program_rom_mode = 1'b0;
    reset_code_rom_n = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // A pending load always takes priority over a simultaneous command.
        cmd_ready = !load_start && !reset;
        err_d     = 1'b0;
        if (load_start) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            len_d   = load_len;
            cnt_d   = 12'd0;
            state_d = CLEAR;
          end
        end else if (cmd_valid && cmd_ready) begin
          cmd_d = cmd_code;
          if (cmd_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = CMD_ISSUE;
          end
        end
      end

      CLEAR: begin
        reset_code_rom_n = 1'b0;
        state_d          = LOAD;
      end

      LOAD: begin
        program_rom_mode = 1'b1;
        byte_ready       = 1'b1;
        if (byte_valid) begin
          data_d = byte_data;
          addr_d = cnt_q;
          cnt_d  = cnt_q + 12'd1;
          if (last_byte) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // Mode stays high one more cycle so the harness commits the last byte.
        program_rom_mode = 1'b1;
        rsp_valid        = 1'b1;
        state_d          = IDLE;
      end

      CMD_ISSUE: begin
        debug_cmd = cmd_q;
`ifdef DEBUG_HOST_TIMEOUT_EN
        tmo_d     = 16'd0;
`endif
        state_d   = CMD_WAIT;
      end

      CMD_WAIT: begin
        if (command_complete) begin
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef DEBUG_HOST_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end

      RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_host_sequencer.sv
`default_nettype none
// Randomized directed bench for debug_host_sequencer with a transaction-level
// reference model of load/command outcomes.
module tb_debug_host_sequencer;

  localparam int ROM_BYTES      = 32;
  localparam int TIMEOUT_CYCLES = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [11:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_error;
  logic        busy;
  logic [3:0]  debug_cmd;
  logic        command_complete;
  logic [7:0]  rom_wr_data;
  logic [11:0] rom_wr_addr;
  logic        program_rom_mode;
  logic        reset_code_rom_n;

  debug_host_sequencer #(
    .ROM_BYTES      (ROM_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_len         (load_len),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .cmd_valid        (cmd_valid),
    .cmd_code         (cmd_code),
    .cmd_ready        (cmd_ready),
    .rsp_valid        (rsp_valid),
    .rsp_error        (rsp_error),
    .busy             (busy),
    .debug_cmd        (debug_cmd),
    .command_complete (command_complete),
    .rom_wr_data      (rom_wr_data),
    .rom_wr_addr      (rom_wr_addr),
    .program_rom_mode (program_rom_mode),
    .reset_code_rom_n (reset_code_rom_n)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Activity counters sampled mid-cycle, used to prove one-cycle pulses
  // and the absence of harness activity on rejected requests.
  int mon_clr_low = 0;
  int mon_rsp     = 0;
  int mon_dbg     = 0;
  int mon_pm      = 0;

  always @(negedge clk) begin
    if (!reset_code_rom_n) mon_clr_low++;
    if (rsp_valid)         mon_rsp++;
    if (debug_cmd != 4'd0) mon_dbg++;
    if (program_rom_mode)  mon_pm++;
  end

  logic [7:0] img[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input int len);
    img.delete();
    for (int i = 0; i < len; i++) img.push_back(8'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_debug_cmd"},  debug_cmd, 0);
    chk({tag, "_wr_data"},    rom_wr_data, 0);
    chk({tag, "_wr_addr"},    rom_wr_addr, 0);
    chk({tag, "_prog_mode"},  program_rom_mode, 0);
    chk({tag, "_rom_rst_n"},  reset_code_rom_n, 1);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_cmd_ready"},  cmd_ready, 0);
    chk({tag, "_rsp_valid"},  rsp_valid, 0);
    chk({tag, "_rsp_error"},  rsp_error, 0);
    chk({tag, "_busy"},       busy, 0);
  endtask

  // Model: a load succeeds iff 1 <= len <= ROM_BYTES; byte k lands at address k.
  task automatic do_load(input int len, input bit hold_cmd, input int abort_after);
    int c0, d0, p0, r0, acc, budget;
    bit legal;
    legal = (len >= 1) && (len <= ROM_BYTES);
    c0 = mon_clr_low; d0 = mon_dbg; p0 = mon_pm; r0 = mon_rsp;
    load_start = 1'b1;
    load_len   = 12'(len);
    if (hold_cmd) begin
      cmd_valid = 1'b1;
      cmd_code  = 4'd1;
    end
    #1 chk("ld_cmd_ready_blocked", cmd_ready, 0);
    cycle();
    load_start = 1'b0;
    if (!legal) begin
      chk("ld_bad_rsp_valid", rsp_valid, 1);
      chk("ld_bad_rsp_error", rsp_error, 1);
      cycle();
      chk("ld_bad_rsp_done", rsp_valid, 0);
      chk("ld_bad_err_low", rsp_error, 0);
      chk("ld_bad_busy", busy, 0);
      chk("ld_bad_no_clear", mon_clr_low - c0, 0);
      chk("ld_bad_no_pm", mon_pm - p0, 0);
      chk("ld_bad_no_dbg", mon_dbg - d0, 0);
      chk("ld_bad_one_rsp", mon_rsp - r0, 1);
      return;
    end
    chk("ld_clear_rom_rst_n", reset_code_rom_n, 0);
    chk("ld_clear_pm", program_rom_mode, 0);
    cycle();
    acc = 0;
    budget = 0;
    while (acc < len && budget < 2000) begin
      if (abort_after >= 0 && acc == abort_after) break;
      byte_valid = ($urandom_range(0, 2) != 0);
      byte_data  = byte_valid ? img[acc] : 8'($urandom);
      #1 chk("ld_byte_ready", byte_ready, 1);
      cycle();
      if (byte_valid) begin
        chk("ld_wr_addr", rom_wr_addr, acc);
        chk("ld_wr_data", rom_wr_data, img[acc]);
        acc++;
      end
      budget++;
    end
    byte_valid = 1'b0;
    if (abort_after >= 0) return;
    chk("ld_all_bytes", acc, len);
    chk("ld_flush_byte_ready", byte_ready, 0);
    chk("ld_flush_pm", program_rom_mode, 1);
    chk("ld_flush_rsp_valid", rsp_valid, 1);
    chk("ld_flush_rsp_error", rsp_error, 0);
    chk("ld_flush_last_addr", rom_wr_addr, len - 1);
    chk("ld_flush_last_data", rom_wr_data, img[len-1]);
    cycle();
    chk("ld_idle_pm", program_rom_mode, 0);
    chk("ld_idle_rsp", rsp_valid, 0);
    chk("ld_idle_busy", busy, 0);
    if (hold_cmd) chk("ld_idle_cmd_ready", cmd_ready, 1);
    chk("ld_one_clear", mon_clr_low - c0, 1);
    chk("ld_one_rsp", mon_rsp - r0, 1);
    chk("ld_no_dbg", mon_dbg - d0, 0);
  endtask

  // Model: codes 1..3 are legal; legal ones respond 3+delay cycles after accept.
  task automatic do_cmd(input int code, input int delay, input bit glitch);
    int c0, d0, p0, r0;
    bit legal;
    legal = (code >= 1) && (code <= 3);
    c0 = mon_clr_low; d0 = mon_dbg; p0 = mon_pm; r0 = mon_rsp;
    cmd_valid = 1'b1;
    cmd_code  = 4'(code);
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    cycle();
    cmd_valid = 1'b0;
    cmd_code  = 4'($urandom);
    if (!legal) begin
      chk("cmd_bad_rsp_valid", rsp_valid, 1);
      chk("cmd_bad_rsp_error", rsp_error, 1);
      chk("cmd_bad_debug_cmd", debug_cmd, 0);
      cycle();
      chk("cmd_bad_rsp_done", rsp_valid, 0);
      chk("cmd_bad_busy", busy, 0);
      chk("cmd_bad_no_dbg", mon_dbg - d0, 0);
      chk("cmd_bad_no_pm", mon_pm - p0, 0);
      chk("cmd_bad_no_clear", mon_clr_low - c0, 0);
      chk("cmd_bad_one_rsp", mon_rsp - r0, 1);
      return;
    end
    chk("cmd_issue_debug_cmd", debug_cmd, code);
    chk("cmd_issue_busy", busy, 1);
    command_complete = glitch;
    cycle();
    command_complete = 1'b0;
    chk("cmd_wait_debug_cmd", debug_cmd, 0);
    chk("cmd_wait_no_rsp", rsp_valid, 0);
    for (int j = 0; j < delay; j++) begin
      cycle();
      chk("cmd_wait_still", rsp_valid, 0);
    end
    command_complete = 1'b1;
    cycle();
    command_complete = 1'b0;
    chk("cmd_rsp_valid", rsp_valid, 1);
    chk("cmd_rsp_error", rsp_error, 0);
    chk("cmd_rsp_debug_cmd", debug_cmd, 0);
    cycle();
    chk("cmd_done_rsp", rsp_valid, 0);
    chk("cmd_done_busy", busy, 0);
    chk("cmd_dbg_one_cycle", mon_dbg - d0, 1);
    chk("cmd_one_rsp", mon_rsp - r0, 1);
    chk("cmd_no_pm", mon_pm - p0, 0);
  endtask

  initial begin
    int r0;
    reset = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0;
    byte_data = '0; cmd_valid = 1'b0; cmd_code = '0; command_complete = 1'b0;
    cycle();
    cycle();
    check_reset_vals("rst");
    reset = 1'b0;
    cycle();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Stray harness/stream activity in IDLE must be ignored.
    r0 = mon_rsp;
    command_complete = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    cycle();
    command_complete = 1'b0;
    byte_valid = 1'b0;
    chk("idle_stray_rsp", mon_rsp - r0, 0);
    chk("idle_stray_busy", busy, 0);
    chk("idle_stray_wr_data", rom_wr_data, 0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h50, 8'h00};
    do_load(8, 1'b0, -1);
    do_cmd(2, 0, 1'b0);

    do_load(0, 1'b0, -1);
    do_load(ROM_BYTES + 1, 1'b0, -1);
    do_cmd(0, 0, 1'b0);
    do_cmd(7, 0, 1'b0);

    fill_img(ROM_BYTES);
    do_load(ROM_BYTES, 1'b0, -1);

    fill_img(5);
    do_load(5, 1'b1, -1);
    do_cmd(1, 0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int len;
        len = $urandom_range(0, ROM_BYTES + 8);
        fill_img(len);
        do_load(len, 1'b0, -1);
      end else begin
        do_cmd($urandom_range(0, 15), $urandom_range(0, 5), 1'($urandom));
      end
    end

    // Reset in the middle of a load.
    fill_img(8);
    r0 = mon_rsp;
    do_load(8, 1'b0, 3);
    reset = 1'b1;
    cycle();
    check_reset_vals("rst_mid_load");
    reset = 1'b0;
    cycle();
    chk("rst_mid_load_no_rsp", mon_rsp - r0, 0);
    chk("rst_mid_load_idle", busy, 0);

    // Command with no completion from the harness.
    r0 = mon_rsp;
    cmd_valid = 1'b1;
    cmd_code = 4'd3;
    cycle();
    cmd_valid = 1'b0;
    cycle();
`ifdef DEBUG_HOST_TIMEOUT_EN
    chk("tmo_wait_1", rsp_valid, 0);
    for (int j = 1; j < TIMEOUT_CYCLES; j++) begin
      cycle();
      chk("tmo_wait_n", rsp_valid, 0);
    end
    cycle();
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_error", rsp_error, 1);
    chk("tmo_debug_cmd", debug_cmd, 0);
    cycle();
    chk("tmo_idle", busy, 0);
    r0 = mon_rsp;
    cmd_valid = 1'b1;
    cmd_code = 4'd3;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    for (int j = 0; j < 3; j++) cycle();
`else
    for (int j = 0; j < 40; j++) cycle();
    chk("nowait_no_rsp", mon_rsp - r0, 0);
    chk("nowait_busy", busy, 1);
`endif
    reset = 1'b1;
    cycle();
    check_reset_vals("rst_mid_wait");
    reset = 1'b0;
    cycle();
    chk("rst_mid_wait_no_rsp", mon_rsp - r0, 0);
    do_cmd(1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
